// File: rtl/round_scorer_if.sv
// Handshake and score bus between a match controller and round_scorer.
// master drives the round results and start; slave is the scorer.
interface round_scorer_if;
  logic       start;
  logic       result_valid;
  logic [1:0] result;
  logic       result_ready;
  logic [3:0] round;
  logic [3:0] win;
  logic [3:0] lose;
  logic [3:0] draws;
  logic       playing;
  logic       done;
  logic       round_pulse;
  logic       err_pulse;
  logic [1:0] state_dbg;

  // Valid/ready: a result transfers on a rising clk edge where result_valid
  // and result_ready are both high; result must be stable while valid is high.
  modport master (
    output start, result_valid, result,
    input  result_ready, round, win, lose, draws, playing, done,
    input  round_pulse, err_pulse, state_dbg
  );

  modport slave (
    input  start, result_valid, result,
    output result_ready, round, win, lose, draws, playing, done,
    output round_pulse, err_pulse, state_dbg
  );
endinterface

// File: rtl/round_scorer.sv
// Round scoring stage: accumulates round/win/lose/draw counts for one match
// and freezes them once MAX_ROUNDS rounds have been scored.
module round_scorer #(
  parameter int MAX_ROUNDS    = 8,
  parameter int DRAW_ADVANCES = 1
) (
  input  logic           clk,
  input  logic           reset,
  round_scorer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS);

  state_t     state;
  logic [3:0] round_q;
  logic [3:0] win_q;
  logic [3:0] lose_q;
  logic [3:0] draws_q;
  logic       round_pulse_q;
  logic       err_pulse_q;
  logic       accept;
  logic [3:0] round_inc;

  assign bus.result_ready = (state == PLAY) & ~bus.start;
  assign accept           = bus.result_valid & bus.result_ready;
  assign round_inc        = round_q + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      round_q       <= 4'd0;
      win_q         <= 4'd0;
      lose_q        <= 4'd0;
      draws_q       <= 4'd0;
      round_pulse_q <= 1'b0;
      err_pulse_q   <= 1'b0;
    end else begin
      round_pulse_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      // start restarts the match from any state; ready is low, so no result is lost to it
      if (bus.start) begin
        state   <= PLAY;
        round_q <= 4'd0;
        win_q   <= 4'd0;
        lose_q  <= 4'd0;
        draws_q <= 4'd0;
      end else if (accept) begin
        case (bus.result)
          2'b01: begin
            win_q         <= win_q + 4'd1;
            round_q       <= round_inc;
            round_pulse_q <= 1'b1;
            if (round_inc == LAST_ROUND) state <= DONE;
          end
          2'b10: begin
            lose_q        <= lose_q + 4'd1;
            round_q       <= round_inc;
            round_pulse_q <= 1'b1;
            if (round_inc == LAST_ROUND) state <= DONE;
          end
          2'b11: begin
            if (draws_q != 4'hF) draws_q <= draws_q + 4'd1;
            round_pulse_q <= 1'b1;
            if (DRAW_ADVANCES != 0) begin
              round_q <= round_inc;
              if (round_inc == LAST_ROUND) state <= DONE;
            end
          end
          default: err_pulse_q <= 1'b1;
        endcase
      end
    end
  end

  assign bus.round       = round_q;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;
  assign bus.draws       = draws_q;
  assign bus.playing     = (state == PLAY);
  assign bus.done        = (state == DONE);
  assign bus.round_pulse = round_pulse_q;
  assign bus.err_pulse   = err_pulse_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_round_scorer.sv
// Bench for round_scorer: two instances (draw advances / draw does not) share
// one stimulus stream and are checked against a score-keeping model.
module tb_round_scorer;

  localparam int MAXR = 8;

  logic clk;
  logic reset;
  logic start;
  logic result_valid;
  logic [1:0] result;

  int n_vec;
  int n_err;

  round_scorer_if bus0 ();
  round_scorer_if bus1 ();

  assign bus0.start        = start;
  assign bus0.result_valid = result_valid;
  assign bus0.result       = result;
  assign bus1.start        = start;
  assign bus1.result_valid = result_valid;
  assign bus1.result       = result;

  round_scorer #(.MAX_ROUNDS(MAXR), .DRAW_ADVANCES(1)) u_adv (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  round_scorer #(.MAX_ROUNDS(MAXR), .DRAW_ADVANCES(0)) u_noadv (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: match phase plus plain integer tallies
  typedef struct {
    int phase;  // 0 idle, 1 play, 2 done
    int round;
    int win;
    int lose;
    int draws;
    bit rp;
    bit ep;
  } mdl_t;

  mdl_t m0;
  mdl_t m1;

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.phase = 0; n.round = 0; n.win = 0; n.lose = 0; n.draws = 0;
    n.rp = 0; n.ep = 0;
    return n;
  endfunction

  function automatic mdl_t mdl_edge(mdl_t m, bit draw_adv, bit s, bit v, logic [1:0] r);
    mdl_t n = m;
    n.rp = 0;
    n.ep = 0;
    if (s) begin
      n = mdl_reset();
      n.phase = 1;
    end else if (m.phase == 1 && v) begin
      if (r == 2'b00) n.ep = 1;
      else begin
        n.rp = 1;
        if (r == 2'b01) n.win++;
        if (r == 2'b10) n.lose++;
        if (r == 2'b11) n.draws = (n.draws < 15) ? n.draws + 1 : 15;
        n.round = n.win + n.lose + (draw_adv ? n.draws : 0);
        if (n.round == MAXR) n.phase = 2;
      end
    end
    return n;
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".a.round"}, 8'(bus0.round), 8'(m0.round));
    chk({ph, ".a.win"},   8'(bus0.win),   8'(m0.win));
    chk({ph, ".a.lose"},  8'(bus0.lose),  8'(m0.lose));
    chk({ph, ".a.draws"}, 8'(bus0.draws), 8'(m0.draws));
    chk({ph, ".a.playing"}, 8'(bus0.playing), 8'(m0.phase == 1));
    chk({ph, ".a.done"},    8'(bus0.done),    8'(m0.phase == 2));
    chk({ph, ".a.rpulse"},  8'(bus0.round_pulse), 8'(m0.rp));
    chk({ph, ".a.epulse"},  8'(bus0.err_pulse),   8'(m0.ep));
    chk({ph, ".a.ready"},   8'(bus0.result_ready), 8'(m0.phase == 1 && !start));
    chk({ph, ".a.inv"}, 8'(bus0.win + bus0.lose + bus0.draws), 8'(bus0.round));
    chk({ph, ".b.round"}, 8'(bus1.round), 8'(m1.round));
    chk({ph, ".b.win"},   8'(bus1.win),   8'(m1.win));
    chk({ph, ".b.lose"},  8'(bus1.lose),  8'(m1.lose));
    chk({ph, ".b.draws"}, 8'(bus1.draws), 8'(m1.draws));
    chk({ph, ".b.playing"}, 8'(bus1.playing), 8'(m1.phase == 1));
    chk({ph, ".b.done"},    8'(bus1.done),    8'(m1.phase == 2));
    chk({ph, ".b.rpulse"},  8'(bus1.round_pulse), 8'(m1.rp));
    chk({ph, ".b.epulse"},  8'(bus1.err_pulse),   8'(m1.ep));
    chk({ph, ".b.ready"},   8'(bus1.result_ready), 8'(m1.phase == 1 && !start));
    chk({ph, ".b.inv"}, 8'(bus1.win + bus1.lose), 8'(bus1.round));
  endtask

  // driver: one clock edge with the currently driven inputs, then check
  task automatic step(input string ph);
    @(posedge clk);
    m0 = mdl_edge(m0, 1'b1, start, result_valid, result);
    m1 = mdl_edge(m1, 1'b0, start, result_valid, result);
    #1;
    check_all(ph);
  endtask

  task automatic drive(input bit s, input bit v, input logic [1:0] r);
    start = s;
    result_valid = v;
    result = r;
  endtask

  task automatic async_reset(input string ph);
    reset = 1'b1;
    #1;
    m0 = mdl_reset();
    m1 = mdl_reset();
    check_all(ph);
    #1;
    reset = 1'b0;
  endtask

  logic [1:0] seq2 [8];
  logic [1:0] seq3 [3];

  initial begin
    n_vec = 0;
    n_err = 0;
    m0 = mdl_reset();
    m1 = mdl_reset();
    reset = 1'b1;
    drive(0, 0, 2'b00);
    #1;
    check_all("reset");
    #12;
    reset = 1'b0;
    step("idle");
    drive(0, 1, 2'b01);
    step("idle_ignore");

    // reset mid-match at round 3, no clock edge needed
    drive(1, 0, 2'b00); step("start1");
    drive(0, 1, 2'b01); step("r1");
    drive(0, 1, 2'b10); step("r2");
    drive(0, 1, 2'b01); step("r3");
    chk("t1.pre_round", 8'(bus0.round), 8'd3);
    drive(0, 0, 2'b00);
    #2;
    async_reset("t1.async");

    // full match
    seq2 = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b01, 2'b01};
    drive(1, 0, 2'b00); step("t2.start");
    for (int i = 0; i < 8; i++) begin
      chk("t2.done_early", 8'(bus0.done), 8'd0);
      drive(0, 1, seq2[i]);
      step($sformatf("t2.r%0d", i));
    end
    chk("t2.round", 8'(bus0.round), 8'd8);
    chk("t2.win",   8'(bus0.win),   8'd5);
    chk("t2.lose",  8'(bus0.lose),  8'd2);
    chk("t2.draws", 8'(bus0.draws), 8'd1);
    chk("t2.done",  8'(bus0.done),  8'd1);
    chk("t2.ready", 8'(bus0.result_ready), 8'd0);

    // results offered in DONE are ignored
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 2'b01);
      step("t3.frozen");
      chk("t3.rpulse", 8'(bus0.round_pulse), 8'd0);
    end
    chk("t3.round", 8'(bus0.round), 8'd8);
    chk("t3.win",   8'(bus0.win),   8'd5);

    // illegal code at round 2
    drive(1, 0, 2'b00); step("t4.start");
    drive(0, 1, 2'b01); step("t4.r1");
    drive(0, 1, 2'b10); step("t4.r2");
    drive(0, 1, 2'b00); step("t4.illegal");
    chk("t4.err", 8'(bus0.err_pulse), 8'd1);
    chk("t4.round", 8'(bus0.round), 8'd2);
    drive(0, 0, 2'b00); step("t4.after");
    chk("t4.err_once", 8'(bus0.err_pulse), 8'd0);

    // restart while a result is offered at round 4
    drive(0, 1, 2'b01); step("t5.r3");
    drive(0, 1, 2'b01); step("t5.r4");
    drive(1, 1, 2'b01);
    #1;
    chk("t5.ready_low", 8'(bus0.result_ready), 8'd0);
    step("t5.restart");
    chk("t5.round", 8'(bus0.round), 8'd0);
    chk("t5.win",   8'(bus0.win),   8'd0);
    chk("t5.playing", 8'(bus0.playing), 8'd1);

    // draws then wins: only the no-advance instance counts all eight wins
    seq3 = '{2'b11, 2'b11, 2'b11};
    drive(1, 0, 2'b00); step("t6.start");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, seq3[i]);
      step("t6.draw");
    end
    for (int i = 0; i < 8; i++) begin
      chk("t6.b.done_early", 8'(bus1.done), 8'd0);
      drive(0, 1, 2'b01);
      step($sformatf("t6.w%0d", i));
    end
    chk("t6.b.draws", 8'(bus1.draws), 8'd3);
    chk("t6.b.round", 8'(bus1.round), 8'd8);
    chk("t6.b.win",   8'(bus1.win),   8'd8);
    chk("t6.b.done",  8'(bus1.done),  8'd1);

    // randomized matches with occasional restarts and resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        drive(0, 0, 2'b00);
        #2;
        async_reset("rnd.reset");
      end
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
